// File: rtl/mem_stage_if.sv
// mem_stage_if
// Groups the EX/MEM fields consumed by the memory stage and the MEM/WB,
// branch and stall fields it produces.
// Ports (signals):
//   MEM*_in          : EX/MEM control and data, driven by the upstream stage
//   PCSrc_out        : taken-branch select
//   BranchTarget_out : branch target address
//   stall            : hold request to upstream stages
//   WB*_out          : registered MEM/WB fields
// Modports: master = upstream driver (EX/MEM side), slave = mem_stage.
interface mem_stage_if;
  logic        MEMMemtoReg_in;
  logic        MEMRegWrite_in;
  logic        MEMMemRead_in;
  logic        MEMMemWrite_in;
  logic        MEMBranch_in;
  logic [31:0] MEMADD_in;
  logic [31:0] MEMALURes_in;
  logic [31:0] MEMRd2_in;
  logic [4:0]  MEMRd_in;
  logic        MEMZero_in;

  logic        PCSrc_out;
  logic [31:0] BranchTarget_out;
  logic        stall;
  logic        WBMemtoReg_out;
  logic        WBRegWrite_out;
  logic [31:0] WBReadData_out;
  logic [31:0] WBALURes_out;
  logic [4:0]  WBRd_out;

  modport master (
    output MEMMemtoReg_in, MEMRegWrite_in, MEMMemRead_in, MEMMemWrite_in,
           MEMBranch_in, MEMADD_in, MEMALURes_in, MEMRd2_in, MEMRd_in,
           MEMZero_in,
    input  PCSrc_out, BranchTarget_out, stall, WBMemtoReg_out,
           WBRegWrite_out, WBReadData_out, WBALURes_out, WBRd_out
  );

  modport slave (
    input  MEMMemtoReg_in, MEMRegWrite_in, MEMMemRead_in, MEMMemWrite_in,
           MEMBranch_in, MEMADD_in, MEMALURes_in, MEMRd2_in, MEMRd_in,
           MEMZero_in,
    output PCSrc_out, BranchTarget_out, stall, WBMemtoReg_out,
           WBRegWrite_out, WBReadData_out, WBALURes_out, WBRd_out
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of a 5-stage RISC-V pipeline. Performs word loads and
// stores on an internal data RAM with WAIT_STATES extra cycles per access,
// resolves branches combinationally and registers the MEM/WB fields.
// Parameters:
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, 4..4096)
//   WAIT_STATES : extra cycles per memory access (0..15)
// Ports:
//   clk : pipeline clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_stage_if.slave carrying EX/MEM inputs and MEM/WB, branch and
//         stall outputs
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
  localparam bit         HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             request;
  logic             stall_int;
  logic             complete;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  logic        wb_memtoreg;
  logic        wb_regwrite;
  logic [31:0] wb_readdata;
  logic [31:0] wb_alures;
  logic [4:0]  wb_rd;

  assign request = bus.MEMMemRead_in | bus.MEMMemWrite_in;
  // Byte offset bits are dropped and upper bits ignored, so addresses alias
  // modulo the RAM size.
  assign idx     = bus.MEMALURes_in[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt numbers the wait cycles from 1; the access completes in the cycle
  // where cnt reaches WAIT_CNT.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (request && HAS_WAIT) begin
          state_next = ST_WAIT;
          cnt_next   = 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_CNT) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // cnt never exceeds WAIT_CNT inside ST_WAIT, so inequality is the same as
  // cnt < WAIT_CNT.
  always_comb begin
    stall_int = 1'b0;
    case (state)
      ST_IDLE: stall_int = request && HAS_WAIT;
      ST_WAIT: stall_int = (cnt != WAIT_CNT);
      default: stall_int = 1'b0;
    endcase
  end

  assign complete = ~stall_int;

  // Writes only on the completing edge and never while reset is asserted,
  // so an access abandoned by reset leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (rst && complete && bus.MEMMemWrite_in) begin
      mem[idx] <= bus.MEMRd2_in;
    end
  end

  // The load samples the RAM before this edge's write lands, giving
  // read-before-write for combined read/write instructions. Stalled edges
  // insert a bubble by clearing only the write-back controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_memtoreg <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_readdata <= '0;
      wb_alures   <= '0;
      wb_rd       <= '0;
    end else if (stall_int) begin
      wb_memtoreg <= 1'b0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_memtoreg <= bus.MEMMemtoReg_in;
      wb_regwrite <= bus.MEMRegWrite_in;
      wb_readdata <= bus.MEMMemRead_in ? mem[idx] : 32'h0;
      wb_alures   <= bus.MEMALURes_in;
      wb_rd       <= bus.MEMRd_in;
    end
  end

  assign bus.PCSrc_out        = bus.MEMBranch_in & bus.MEMZero_in;
  assign bus.BranchTarget_out = bus.MEMADD_in;
  assign bus.stall            = stall_int;
  assign bus.WBMemtoReg_out   = wb_memtoreg;
  assign bus.WBRegWrite_out   = wb_regwrite;
  assign bus.WBReadData_out   = wb_readdata;
  assign bus.WBALURes_out     = wb_alures;
  assign bus.WBRd_out         = wb_rd;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Self-checking bench for mem_stage. Three instances share one stimulus bus:
//   sel 0 : WAIT_STATES=0, DEPTH_WORDS=256
//   sel 1 : WAIT_STATES=2, DEPTH_WORDS=16
//   sel 2 : WAIT_STATES=3, DEPTH_WORDS=64
// Only the selected instance is checked; all are reset when the selection
// changes so their FSMs start from IDLE.
module tb_mem_stage;

  typedef struct {
    int          sel;
    logic        mr, mw, m2r, rw, br, z;
    logic [31:0] add, alu, rd2;
    logic [4:0]  rd;
    logic [31:0] expData;
    int          expStall;
  } vec_t;

  logic clk;
  logic rst;

  logic        memtoReg, regWrite, memRead, memWrite, branch, zero;
  logic [31:0] addIn, aluIn, rd2In;
  logic [4:0]  rdIn;

  logic [2:0]  oStall, oPcSrc, oM2r, oRw;
  logic [31:0] oTarget [3];
  logic [31:0] oData   [3];
  logic [31:0] oAlu    [3];
  logic [4:0]  oRd     [3];

  int sel;
  int total;
  int bad;

  logic [31:0] prevAlu, prevData;
  logic [4:0]  prevRd;

  logic [31:0] modelMem [int];

  // One DUT per parameter set, all fed from the same stimulus variables.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_if bus();

    assign bus.MEMMemtoReg_in = memtoReg;
    assign bus.MEMRegWrite_in = regWrite;
    assign bus.MEMMemRead_in  = memRead;
    assign bus.MEMMemWrite_in = memWrite;
    assign bus.MEMBranch_in   = branch;
    assign bus.MEMADD_in      = addIn;
    assign bus.MEMALURes_in   = aluIn;
    assign bus.MEMRd2_in      = rd2In;
    assign bus.MEMRd_in       = rdIn;
    assign bus.MEMZero_in     = zero;

    assign oStall[g]  = bus.stall;
    assign oPcSrc[g]  = bus.PCSrc_out;
    assign oM2r[g]    = bus.WBMemtoReg_out;
    assign oRw[g]     = bus.WBRegWrite_out;
    assign oTarget[g] = bus.BranchTarget_out;
    assign oData[g]   = bus.WBReadData_out;
    assign oAlu[g]    = bus.WBALURes_out;
    assign oRd[g]     = bus.WBRd_out;

    mem_stage #(
      .DEPTH_WORDS(g == 0 ? 256 : (g == 1 ? 16 : 64)),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsOf(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
  endfunction

  function automatic int depthOf(input int s);
    return (s == 0) ? 256 : ((s == 1) ? 16 : 64);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (sel=%0d t=%0t)",
               name, act, exp, sel, $time);
    end
  endtask

  task automatic setIdleInputs();
    memtoReg = 0; regWrite = 0; memRead = 0; memWrite = 0;
    branch = 0; zero = 0; addIn = 0; aluIn = 0; rd2In = 0; rdIn = 0;
  endtask

  task automatic resetAll();
    @(posedge clk);
    #1;
    setIdleInputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    prevAlu = 0; prevData = 0; prevRd = 0;
  endtask

  // Drives one instruction, counts stalled cycles, checks bubbles on stalled
  // edges and the MEM/WB fields after the completing edge.
  task automatic applyStimulus(input vec_t v, input string name);
    int  stallCnt;
    bit  done;
    memRead = v.mr; memWrite = v.mw; memtoReg = v.m2r; regWrite = v.rw;
    branch = v.br; zero = v.z; addIn = v.add; aluIn = v.alu;
    rd2In = v.rd2; rdIn = v.rd;
    stallCnt = 0;
    done = 0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput({name, ".pcsrc"}, 32'(oPcSrc[sel]), 32'(v.br & v.z));
        checkOutput({name, ".target"}, oTarget[sel], v.add);
      end
      if (oStall[sel]) begin
        stallCnt++;
        @(posedge clk);
        #1;
        checkOutput({name, ".bubble_rw"}, 32'(oRw[sel]), 0);
        checkOutput({name, ".bubble_m2r"}, 32'(oM2r[sel]), 0);
        checkOutput({name, ".hold_alu"}, oAlu[sel], prevAlu);
        checkOutput({name, ".hold_rd"}, 32'(oRd[sel]), 32'(prevRd));
        checkOutput({name, ".hold_data"}, oData[sel], prevData);
      end else begin
        @(posedge clk);
        #1;
        checkOutput({name, ".wb_rw"}, 32'(oRw[sel]), 32'(v.rw));
        checkOutput({name, ".wb_m2r"}, 32'(oM2r[sel]), 32'(v.m2r));
        checkOutput({name, ".wb_alu"}, oAlu[sel], v.alu);
        checkOutput({name, ".wb_rd"}, 32'(oRd[sel]), 32'(v.rd));
        checkOutput({name, ".wb_data"}, oData[sel], v.expData);
        prevAlu = v.alu; prevRd = v.rd; prevData = v.expData;
        done = 1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.timeout: stall still high after 20 cycles, required low", name);
    end else begin
      checkOutput({name, ".stall_cycles"}, 32'(stallCnt), 32'(v.expStall));
    end
  endtask

  function automatic logic [31:0] makeAddr(input int idx, input int depth);
    logic [31:0] mask;
    mask = 32'(depth * 4 - 1);
    return ($urandom & ~mask) | 32'(idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  vec_t vecs [10];

  initial begin
    vec_t v;
    total = 0;
    bad = 0;
    sel = 0;

    // Directed vectors: sel, mr, mw, m2r, rw, br, z, add, alu, rd2, rd,
    // expected read data, expected stall cycles.
    vecs[0] = '{1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 2};
    vecs[1] = '{1, 1, 0, 1, 1, 0, 0, 32'h0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 2};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h20, 32'h1, 5'd0, 32'h0, 2};
    vecs[3] = '{1, 1, 1, 1, 1, 0, 0, 32'h0, 32'h20, 32'h2, 5'd6, 32'h1, 2};
    vecs[4] = '{1, 1, 0, 1, 1, 0, 0, 32'h0, 32'h20, 32'h0, 5'd6, 32'h2, 2};
    vecs[5] = '{0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h404, 32'h12345678, 5'd0, 32'h0, 0};
    vecs[6] = '{0, 1, 0, 1, 1, 0, 0, 32'h0, 32'h004, 32'h0, 5'd3, 32'h12345678, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h0, 32'h0, 5'd0, 32'h0, 0};
    vecs[8] = '{0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h55, 32'h0, 5'd7, 32'h0, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 32'h0, 5'd0, 32'h0, 0};

    // Reset with random inputs, a request present throughout.
    rst = 1'b1;
    memtoReg = 1; regWrite = 1; memRead = 1; memWrite = 1'($urandom);
    branch = 0; zero = 1'($urandom);
    addIn = $urandom; aluIn = $urandom; rd2In = $urandom; rdIn = 5'($urandom);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      sel = g;
      checkOutput("rst.wb_rw", 32'(oRw[g]), 0);
      checkOutput("rst.wb_m2r", 32'(oM2r[g]), 0);
      checkOutput("rst.wb_data", oData[g], 0);
      checkOutput("rst.wb_alu", oAlu[g], 0);
      checkOutput("rst.wb_rd", 32'(oRd[g]), 0);
      checkOutput("rst.stall_idle_decode", 32'(oStall[g]), 32'(wsOf(g) != 0));
    end
    setIdleInputs();
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      sel = g;
      checkOutput("rst.release_stall", 32'(oStall[g]), 0);
    end

    // Directed table.
    sel = -1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sel != sel) begin
        sel = vecs[i].sel;
        resetAll();
      end
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset abandoned mid-WAIT on the WAIT_STATES=3 instance.
    sel = 2;
    resetAll();
    v = '{2, 0, 1, 0, 0, 0, 0, 32'h0, 32'h30, 32'h1111, 5'd0, 32'h0, 3};
    applyStimulus(v, "midw.prior_store");
    memRead = 0; memWrite = 1; memtoReg = 0; regWrite = 0;
    aluIn = 32'h30; rd2In = 32'hAAAA; rdIn = 0;
    @(negedge clk);
    checkOutput("midw.stall_c1", 32'(oStall[sel]), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midw.stall_c2", 32'(oStall[sel]), 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midw.rst_alu", oAlu[sel], 0);
    checkOutput("midw.rst_rw", 32'(oRw[sel]), 0);
    checkOutput("midw.rst_stall", 32'(oStall[sel]), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    prevAlu = 0; prevData = 0; prevRd = 0;
    v = '{2, 1, 0, 1, 1, 0, 0, 32'h0, 32'h30, 32'h0, 5'd9, 32'h1111, 3};
    applyStimulus(v, "midw.load_after");

    // Randomized instructions against a word-indexed memory model.
    for (int s = 0; s < 3; s++) begin
      int ws;
      int depth;
      sel = s;
      ws = wsOf(s);
      depth = depthOf(s);
      resetAll();
      modelMem.delete();
      for (int n = 0; n < 38; n++) begin
        int kind;
        int idx;
        kind = (n < 8) ? 2 : $urandom_range(0, 4);
        idx = (n < 8) ? n : $urandom_range(0, 7);
        v.sel = s;
        v.mr = 0; v.mw = 0; v.br = 0; v.z = 1'($urandom);
        v.m2r = 1'($urandom); v.rw = 1'($urandom);
        v.add = $urandom; v.alu = $urandom; v.rd2 = $urandom;
        v.rd = 5'($urandom);
        case (kind)
          1: v.mr = 1;
          2: v.mw = 1;
          3: begin v.mr = 1; v.mw = 1; end
          4: v.br = 1;
          default: ;
        endcase
        if (v.mr || v.mw) v.alu = makeAddr(idx, depth);
        v.expData  = v.mr ? modelMem[(v.alu >> 2) % depth] : 32'h0;
        v.expStall = (v.mr || v.mw) ? ws : 0;
        applyStimulus(v, $sformatf("rnd%0d_%0d", s, n));
        if (v.mw) modelMem[(v.alu >> 2) % depth] = v.rd2;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, placed directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data fields and performs word loads and stores against an internal data RAM with a configurable wait-state count. It resolves the branch decision and registers the MEM/WB pipeline fields for write-back. A small FSM asserts `stall` so upstream stages hold their state during multi-cycle accesses.

## Interface
- `DEPTH_WORDS`, default 256: data RAM depth in 32-bit words; power of two, 4..4096.
- `WAIT_STATES`, default 1: extra cycles per memory access, 0..15.

- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `MEMMemtoReg_in`, `MEMRegWrite_in`, `MEMMemRead_in`, `MEMMemWrite_in`, `MEMBranch_in`  input  1 each  control fields from EX/MEM.
- `MEMADD_in`  input  32  branch target address.
- `MEMALURes_in`  input  32  ALU result; this is the memory address for loads and stores.
- `MEMRd2_in`  input  32  store data.
- `MEMRd_in`  input  5  destination register.
- `MEMZero_in`  input  1  ALU zero flag.
- `PCSrc_out`  output  1  taken-branch select; combinational, equal to `MEMBranch_in & MEMZero_in`.
- `BranchTarget_out`  output  32  combinational copy of `MEMADD_in`.
- `stall`  output  1  combinational; high while an access is incomplete.
- `WBMemtoReg_out`, `WBRegWrite_out`  output  1 each  registered MEM/WB control.
- `WBReadData_out`  output  32  registered load data.
- `WBALURes_out`  output  32  registered ALU result.
- `WBRd_out`  output  5  registered destination register.

## Operation
- **Addressing**
  - Word index is `MEMALURes_in[log2(DEPTH_WORDS)+1:2]`.
  - Bits [1:0] are ignored.
  - Upper address bits are ignored, so addresses alias modulo the RAM size.
- **Access requests**
  - A request is present when `MEMMemRead_in | MEMMemWrite_in`.
  - Upstream holds all inputs stable while `stall` = 1.
- **FSM states**
  - IDLE
    - No request: the instruction completes this cycle.
    - Request with `WAIT_STATES` = 0: completes this cycle.
    - Request with `WAIT_STATES` > 0: `stall` = 1, counter `cnt` <= 1, go to WAIT.
  - WAIT
    - `stall` = (`cnt` < `WAIT_STATES`); `cnt` increments each cycle.
    - When `cnt` = `WAIT_STATES`, `stall` = 0 and the access completes; next state is IDLE and `cnt` <= 0.
- **At the completing edge**
  - Store: `mem[idx] <= MEMRd2_in`. The write happens exactly once per instruction.
  - Load: `WBReadData_out <= mem[idx]`. Non-load instructions load 0 into `WBReadData_out`.
  - Read and write in the same instruction: the read returns the old contents (read-before-write) and the write still commits.
  - MEM/WB fields load from the inputs: `WBMemtoReg_out`, `WBRegWrite_out`, `WBALURes_out`, `WBRd_out`.
- **Stalled edges**
  - A bubble is inserted: `WBRegWrite_out` <= 0 and `WBMemtoReg_out` <= 0.
  - Other MEM/WB fields hold their values.
  - No RAM write occurs.
- **Branch resolution**
  - Purely combinational and independent of the FSM.
  - Branches never carry a memory request.
- **RAM contents**
  - Not reset and not initialised; contents are undefined until written.

## Timing
- **Reset (`rst` = 0)**
  - FSM goes to IDLE and `cnt` = 0.
  - All WB outputs = 0.
  - `stall` reflects IDLE decoding of the current inputs.
- **Reset mid-WAIT**
  - The access is abandoned and no RAM write commits.
  - After release, the held request restarts from IDLE with the full wait count.
- **Latency**
  - A memory instruction takes `WAIT_STATES`+1 cycles; the WB outputs are valid the cycle after the completing edge.
  - A non-memory instruction takes 1 cycle.
- **Stall duration**
  - `stall` is high for exactly `WAIT_STATES` consecutive cycles per memory instruction, starting in the cycle the request appears in IDLE.
- **Back-to-back**
  - A request present in IDLE immediately after a completion starts a new access with no idle gap.

## Test plan
- **Reset**: `rst` low with random inputs -> all WB outputs 0; after release with no request, `stall` = 0.
- **Store then load, `WAIT_STATES`=2**
  - Store 0xDEADBEEF to address 0x10 -> `stall` high for exactly 2 cycles and a single write.
  - Load from 0x10 -> `WBReadData_out` = 0xDEADBEEF, `WBRegWrite_out` = 1 after 3 cycles.
  - Bubbles (`WBRegWrite_out` = 0) appear on the stalled edges.
- **`WAIT_STATES`=0, DEPTH_WORDS=256**
  - Store 0x12345678 to 0x404, then load from 0x004 -> aliasing returns 0x12345678.
  - `stall` never asserts.
- **Read+write same instruction**: address 0x20 holds 0x1, store 0x2 with MemRead=1 -> `WBReadData_out` = 0x1; a later load returns 0x2.
- **Branch and R-type**
  - Branch=1, Zero=1, ADD=0x80 -> `PCSrc_out` = 1, `BranchTarget_out` = 0x80, no stall.
  - R-type with ALURes=0x55, Rd=7, RegWrite=1 -> `WBALURes_out` = 0x55, `WBRd_out` = 7, `WBReadData_out` = 0 next cycle.
- **Reset mid-WAIT, `WAIT_STATES`=3**
  - Assert `rst` during cycle 2 of a store of 0xAAAA to 0x30.
  - A later load from 0x30 returns the prior value, proving no partial write.
